// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle RV32I sequencer: FSM state encoding,
// trap cause codes, default parameter values and small state-class helpers.
// -----------------------------------------------------------------------------
package mc_pkg;

    localparam int          MC_XLEN_DEF     = 32;
    localparam logic [31:0] MC_RESET_PC_DEF = 32'h0000_0000;
    localparam int          MC_MAX_WAIT_DEF = 15;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH_REQ  = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_DECODE     = 4'd3,
        ST_EXECUTE    = 4'd4,
        ST_MEM_REQ    = 4'd5,
        ST_MEM_WAIT   = 4'd6,
        ST_WRITEBACK  = 4'd7,
        ST_TRAP       = 4'd8
    } state_t;

    localparam logic [1:0] TRAP_ILLEGAL  = 2'd0;
    localparam logic [1:0] TRAP_FTO      = 2'd1;
    localparam logic [1:0] TRAP_DTO      = 2'd2;
    localparam logic [1:0] TRAP_MISALIGN = 2'd3;

    // True in the states that sit on the memory port (request or response wait).
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) ||
               (s == ST_MEM_REQ)   || (s == ST_MEM_WAIT);
    endfunction

    // True in every state that counts as actively sequencing an instruction.
    function automatic logic is_busy_state(input state_t s);
        return (s != ST_IDLE) && (s != ST_TRAP);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// -----------------------------------------------------------------------------
// mc_wait_timer
// Saturating cycle counter guarding a memory request/response pair.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : return count to zero (held while outside a memory pair)
//   i_en           : count this cycle
//   o_expired      : the current cycle is the MAX_WAIT-th spent in the pair
// -----------------------------------------------------------------------------
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = MC_MAX_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int         W     = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] SAT   = W'(MAX_WAIT);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT - 1);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] r_cnt;

    // Count completed cycles in the pair, saturating so it can never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    // r_cnt holds the cycles already spent, so cnt == MAX_WAIT-1 marks the
    // MAX_WAIT-th cycle.
    assign o_expired = (r_cnt >= LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencer for the RV32I datapath. Owns PC, IR and the load-data
// latch and steps FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK over a single
// shared req/gnt/rvalid memory port, trapping on illegal instructions,
// misaligned targets and memory timeouts.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_en                      run enable (looked at in IDLE and WRITEBACK)
//   o_mem_req/we/addr/wdata   memory request side (registered, stable till gnt)
//   i_mem_gnt/rvalid/rdata    memory grant and response
//   i_dec_*                   decoder class flags for the current IR
//   i_branch_taken            branch outcome from the ALU
//   i_alu_result              effective address or jump/branch target
//   i_store_data              aligned store data
//   o_pc, o_ir, o_load_data   architectural registers
//   o_rf_we, o_retire         one-cycle strobes during WRITEBACK
//   o_busy, o_trap, o_trap_cause  status
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int              XLEN     = MC_XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(MC_RESET_PC_DEF),
    parameter int              MAX_WAIT = MC_MAX_WAIT_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_dec_load,
    input  logic            i_dec_store,
    input  logic            i_dec_jump,
    input  logic            i_dec_illegal,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_store_data,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_ir,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_rf_we,
    output logic            o_retire,
    output logic            o_busy,
    output logic            o_trap,
    output logic [1:0]      o_trap_cause
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] r_load_data;
    logic            w_ir_load;
    logic            w_ld_load;
    logic [1:0]      r_trap_cause;
    logic [1:0]      w_cause_next;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_rf_we;
    logic            r_retire;
    logic            r_busy;
    logic            r_trap;
    logic            w_expired;
    logic            w_redirect;
    logic            w_tgt_bad;
    logic            w_ls;
    logic [XLEN-1:0] w_target;

    // Timer is held clear outside a memory pair, so it starts at zero on
    // every entry to FETCH_REQ / MEM_REQ.
    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (!is_mem_state(r_state)),
        .i_en      (is_mem_state(r_state)),
        .o_expired (w_expired)
    );

    assign w_redirect = i_dec_jump | i_branch_taken;
    assign w_target   = {i_alu_result[XLEN-1:1], 1'b0};
    assign w_tgt_bad  = w_redirect & i_alu_result[1];
    assign w_ls       = i_dec_load | i_dec_store;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, PC update and latch enables.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_load    = 1'b0;
        w_ld_load    = 1'b0;
        w_cause_next = r_trap_cause;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_next = ST_FETCH_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FETCH_REQ: begin
                // gnt with rvalid in the same cycle skips the wait state.
                if (i_mem_gnt && i_mem_rvalid) begin
                    w_state_next = ST_DECODE;
                    w_ir_load    = 1'b1;
                end else if (i_mem_gnt) begin
                    w_state_next = ST_FETCH_WAIT;
                end else if (w_expired) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = TRAP_FTO;
                end else begin
                    w_state_next = ST_FETCH_REQ;
                end
            end
            ST_FETCH_WAIT: begin
                if (i_mem_rvalid) begin
                    w_state_next = ST_DECODE;
                    w_ir_load    = 1'b1;
                end else if (w_expired) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = TRAP_FTO;
                end else begin
                    w_state_next = ST_FETCH_WAIT;
                end
            end
            ST_DECODE: begin
                w_state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (i_dec_illegal) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = TRAP_ILLEGAL;
                end else if (w_ls && (i_alu_result[1:0] != 2'b00)) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = TRAP_MISALIGN;
                end else if (w_ls) begin
                    w_state_next = ST_MEM_REQ;
                end else begin
                    w_state_next = ST_WRITEBACK;
                end
            end
            ST_MEM_REQ: begin
                if (i_mem_gnt && i_mem_rvalid) begin
                    w_state_next = ST_WRITEBACK;
                    w_ld_load    = i_dec_load;
                end else if (i_mem_gnt) begin
                    w_state_next = ST_MEM_WAIT;
                end else if (w_expired) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = TRAP_DTO;
                end else begin
                    w_state_next = ST_MEM_REQ;
                end
            end
            ST_MEM_WAIT: begin
                if (i_mem_rvalid) begin
                    w_state_next = ST_WRITEBACK;
                    w_ld_load    = i_dec_load;
                end else if (w_expired) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = TRAP_DTO;
                end else begin
                    w_state_next = ST_MEM_WAIT;
                end
            end
            ST_WRITEBACK: begin
                // A misaligned redirect target traps with the PC left on the
                // faulting instruction.
                if (w_tgt_bad) begin
                    w_state_next = ST_TRAP;
                    w_cause_next = TRAP_MISALIGN;
                end else begin
                    if (w_redirect) begin
                        w_pc_next = w_target;
                    end else begin
                        w_pc_next = r_pc + PC_STEP;
                    end
                    if (i_en) begin
                        w_state_next = ST_FETCH_REQ;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_TRAP: begin
                w_state_next = ST_TRAP;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Architectural registers: PC, IR, load data and sticky trap cause.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_load_data  <= '0;
            r_trap_cause <= 2'd0;
        end else begin
            r_pc         <= w_pc_next;
            r_trap_cause <= w_cause_next;
            if (w_ir_load) begin
                r_ir <= i_mem_rdata;
            end
            if (w_ld_load) begin
                r_load_data <= i_mem_rdata;
            end
        end
    end

    // Registered status and strobes, decoded from the state being entered so
    // they line up with that state. retire/rf_we are suppressed up front when
    // WRITEBACK is going to trap on a misaligned target.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retire <= 1'b0;
            r_rf_we  <= 1'b0;
            r_busy   <= 1'b0;
            r_trap   <= 1'b0;
        end else begin
            r_retire <= (w_state_next == ST_WRITEBACK) && !w_tgt_bad;
            r_rf_we  <= (w_state_next == ST_WRITEBACK) && !w_tgt_bad && !i_dec_store;
            r_busy   <= is_busy_state(w_state_next);
            r_trap   <= (w_state_next == ST_TRAP);
        end
    end

    // Memory request registers: captured once on entry to a REQ state and
    // held unchanged until the grant moves the FSM on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_state_next == ST_FETCH_REQ) begin
            r_mem_req <= 1'b1;
            if (r_state != ST_FETCH_REQ) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= w_pc_next;
                r_mem_wdata <= '0;
            end
        end else if (w_state_next == ST_MEM_REQ) begin
            r_mem_req <= 1'b1;
            if (r_state != ST_MEM_REQ) begin
                r_mem_we    <= i_dec_store;
                r_mem_addr  <= i_alu_result;
                r_mem_wdata <= i_store_data;
            end
        end else begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_pc         = r_pc;
    assign o_ir         = r_ir;
    assign o_load_data  = r_load_data;
    assign o_rf_we      = r_rf_we;
    assign o_retire     = r_retire;
    assign o_busy       = r_busy;
    assign o_trap       = r_trap;
    assign o_trap_cause = r_trap_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        dec_load;
    logic        dec_store;
    logic        dec_jump;
    logic        dec_illegal;
    logic        branch_taken;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] load_data;
    logic        rf_we;
    logic        retire;
    logic        busy;
    logic        trap;
    logic [1:0]  trap_cause;

    int checks;
    int failures;

    multicycle_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_gnt      (mem_gnt),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata),
        .i_dec_load     (dec_load),
        .i_dec_store    (dec_store),
        .i_dec_jump     (dec_jump),
        .i_dec_illegal  (dec_illegal),
        .i_branch_taken (branch_taken),
        .i_alu_result   (alu_result),
        .i_store_data   (store_data),
        .o_pc           (pc),
        .o_ir           (ir),
        .o_load_data    (load_data),
        .o_rf_we        (rf_we),
        .o_retire       (retire),
        .o_busy         (busy),
        .o_trap         (trap),
        .o_trap_cause   (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        dec_load = 1'b0; dec_store = 1'b0; dec_jump = 1'b0; dec_illegal = 1'b0;
        branch_taken = 1'b0; alu_result = 32'h0; store_data = 32'h0;
    endtask

    // Holds reset for two cycles and releases it on a falling edge; the
    // caller raising en right after makes the next edge enter FETCH_REQ.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Zero-wait fetch: called on the falling edge before FETCH_REQ, returns
    // on the falling edge inside DECODE.
    task automatic drive_fetch(input logic [31:0] instr);
        @(negedge clk); mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = instr;
        @(negedge clk); mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=%h", ir, 32'h0); end
        checks++; if ({mem_req, mem_we, busy, trap, retire, rf_we} !== 6'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=%b", {mem_req, mem_we, busy, trap, retire, rf_we}, 6'b0); end
        checks++; if ({trap_cause, load_data, mem_addr} !== 66'h0) begin
            failures++; $display("FAIL reset_regs got=%h exp=0", {trap_cause, load_data, mem_addr}); end
    endtask

    task automatic test_addi();
        do_reset();
        en = 1'b1;
        @(negedge clk); // cycle 1: FETCH_REQ
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            failures++; $display("FAIL addi_fetch_req got=%b/%b/%h exp=1/0/00000000", mem_req, mem_we, mem_addr); end
        mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        @(negedge clk); mem_rvalid = 1'b0; // cycle 3: DECODE
        checks++; if (ir !== 32'h0050_0093) begin failures++; $display("FAIL addi_ir got=%h exp=%h", ir, 32'h0050_0093); end
        @(negedge clk); // cycle 4: EXECUTE
        checks++; if (retire !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL addi_exec got=retire%b busy%b exp=retire0 busy1", retire, busy); end
        @(negedge clk); // cycle 5: WRITEBACK
        checks++; if (retire !== 1'b1 || rf_we !== 1'b1 || pc !== 32'h0) begin
            failures++; $display("FAIL addi_wb got=%b/%b/%h exp=1/1/00000000", retire, rf_we, pc); end
        @(negedge clk); // cycle 6: next FETCH_REQ
        checks++; if (retire !== 1'b0 || rf_we !== 1'b0 || pc !== 32'h4 || mem_addr !== 32'h4) begin
            failures++; $display("FAIL addi_next got=%b/%b/%h/%h exp=0/0/4/4", retire, rf_we, pc, mem_addr); end
    endtask

    task automatic test_load_wait();
        do_reset();
        en = 1'b1;
        drive_fetch(32'h1000_2083);
        dec_load = 1'b1; alu_result = 32'h0000_0100;
        @(negedge clk); // 4: EXECUTE
        @(negedge clk); // 5: MEM_REQ
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            failures++; $display("FAIL lw_req got=%b/%b/%h exp=1/0/00000100", mem_req, mem_we, mem_addr); end
        mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; // 6: MEM_WAIT
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lw_req_drop got=%b exp=0", mem_req); end
        repeat (3) @(negedge clk); // 9: response arrives
        checks++; if (retire !== 1'b0) begin failures++; $display("FAIL lw_early_retire got=%b exp=0", retire); end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); mem_rvalid = 1'b0; // 10: WRITEBACK
        checks++; if (retire !== 1'b1 || rf_we !== 1'b1 || load_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL lw_wb got=%b/%b/%h exp=1/1/deadbeef", retire, rf_we, load_data); end
        dec_load = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL lw_pc got=%h exp=%h", pc, 32'h4); end
    endtask

    task automatic test_store_stall();
        do_reset();
        en = 1'b1;
        drive_fetch(32'h2020_2223);
        dec_store = 1'b1; alu_result = 32'h0000_0204; store_data = 32'hCAFE_0001;
        @(negedge clk); // 4: EXECUTE
        @(negedge clk); // 5: MEM_REQ, grant withheld
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'hCAFE_0001) begin
            failures++; $display("FAIL sw_req got=%b/%b/%h/%h exp=1/1/00000204/cafe0001", mem_req, mem_we, mem_addr, mem_wdata); end
        alu_result = 32'h0000_0300; store_data = 32'h0;
        @(negedge clk); // 6: still MEM_REQ, request must not move
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'hCAFE_0001) begin
            failures++; $display("FAIL sw_hold got=%b/%b/%h/%h exp=1/1/00000204/cafe0001", mem_req, mem_we, mem_addr, mem_wdata); end
        alu_result = 32'h0000_0204;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b0; // 7: WRITEBACK
        checks++; if (retire !== 1'b1 || rf_we !== 1'b0 || load_data !== 32'h0) begin
            failures++; $display("FAIL sw_wb got=%b/%b/%h exp=1/0/00000000", retire, rf_we, load_data); end
        dec_store = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL sw_pc got=%h exp=%h", pc, 32'h4); end
    endtask

    task automatic test_jump();
        do_reset();
        en = 1'b1;
        drive_fetch(32'h0400_006F);
        dec_jump = 1'b1; alu_result = 32'h0000_0041;
        @(negedge clk); // 4: EXECUTE
        @(negedge clk); // 5: WRITEBACK
        checks++; if (retire !== 1'b1 || rf_we !== 1'b1) begin
            failures++; $display("FAIL jal_wb got=%b/%b exp=1/1", retire, rf_we); end
        drive_fetch(32'h0020_80E7); // returns in DECODE of the JALR
        checks++; if (pc !== 32'h40) begin failures++; $display("FAIL jal_pc got=%h exp=%h", pc, 32'h40); end
        alu_result = 32'h0000_0042;
        @(negedge clk); // EXECUTE
        @(negedge clk); // WRITEBACK, target bit 1 set
        checks++; if (retire !== 1'b0 || rf_we !== 1'b0) begin
            failures++; $display("FAIL jalr_no_retire got=%b/%b exp=0/0", retire, rf_we); end
        @(negedge clk);
        checks++; if (trap !== 1'b1 || trap_cause !== 2'd3 || busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL jalr_trap got=%b/%0d/%b/%b exp=1/3/0/0", trap, trap_cause, busy, mem_req); end
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        en = 1'b1;
        repeat (15) @(negedge clk); // cycles 1..15 in FETCH_REQ, no grant
        checks++; if (mem_req !== 1'b1 || trap !== 1'b0) begin
            failures++; $display("FAIL fto_pending got=%b/%b exp=1/0", mem_req, trap); end
        @(negedge clk); // 16
        checks++; if (trap !== 1'b1 || trap_cause !== 2'd1 || busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL fto_trap got=%b/%0d/%b/%b exp=1/1/0/0", trap, trap_cause, busy, mem_req); end
        mem_gnt = 1'b1;
        repeat (4) @(negedge clk);
        mem_gnt = 1'b0;
        checks++; if (trap !== 1'b1 || mem_req !== 1'b0 || pc !== 32'h0) begin
            failures++; $display("FAIL fto_sticky got=%b/%b/%h exp=1/0/00000000", trap, mem_req, pc); end
    endtask

    task automatic test_exec_traps();
        do_reset();
        en = 1'b1;
        @(negedge clk); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b0; // DECODE straight from FETCH_REQ
        checks++; if (ir !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ill_ir got=%h exp=%h", ir, 32'hFFFF_FFFF); end
        dec_illegal = 1'b1;
        @(negedge clk); // EXECUTE
        @(negedge clk);
        checks++; if (trap !== 1'b1 || trap_cause !== 2'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL ill_trap got=%b/%0d/%b exp=1/0/0", trap, trap_cause, busy); end
        do_reset();
        en = 1'b1;
        drive_fetch(32'h1020_2083);
        dec_load = 1'b1; alu_result = 32'h0000_0102;
        @(negedge clk); // EXECUTE
        @(negedge clk);
        checks++; if (trap !== 1'b1 || trap_cause !== 2'd3 || mem_req !== 1'b0) begin
            failures++; $display("FAIL mis_ld_trap got=%b/%0d/%b exp=1/3/0", trap, trap_cause, mem_req); end
    endtask

    task automatic test_en_drop();
        do_reset();
        en = 1'b1;
        drive_fetch(32'h0010_0113);
        @(negedge clk); en = 1'b0; // EXECUTE
        @(negedge clk); // WRITEBACK
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL endrop_retire got=%b exp=1", retire); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || pc !== 32'h4) begin
            failures++; $display("FAIL endrop_idle got=%b/%b/%h exp=0/0/00000004", busy, mem_req, pc); end
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL endrop_quiet got=%b exp=0", mem_req); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            failures++; $display("FAIL endrop_resume got=%b/%h exp=1/00000004", mem_req, mem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        en = 1'b1;
        drive_fetch(32'h0040_2183);
        dec_load = 1'b1; alu_result = 32'h0000_0080;
        @(negedge clk); // EXECUTE
        @(negedge clk); mem_gnt = 1'b1; // MEM_REQ
        @(negedge clk); mem_gnt = 1'b0; // MEM_WAIT
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, busy, retire, rf_we, trap} !== 5'b0 || pc !== 32'h0 || ir !== 32'h0 || load_data !== 32'h0) begin
            failures++; $display("FAIL rst_async got=%b/%h/%h/%h exp=00000/0/0/0", {mem_req, busy, retire, rf_we, trap}, pc, ir, load_data); end
        @(negedge clk);
        rst_n = 1'b1; dec_load = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; // stale response
        @(negedge clk); mem_rvalid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || load_data !== 32'h0 || ir !== 32'h0) begin
            failures++; $display("FAIL rst_restart got=%b/%h/%h/%h exp=1/0/0/0", mem_req, mem_addr, load_data, ir); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_addi();
        test_load_wait();
        test_store_stall();
        test_jump();
        test_fetch_timeout();
        test_exec_traps();
        test_en_drop();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle sequencer for the RV32I datapath, taking over from the single-cycle top's implicit one-instruction-per-clock sequencing. Owns the PC and instruction register and runs an explicit FSM through fetch, decode, execute, memory and writeback. Drives one shared instruction/data memory port through a req/gnt/rvalid handshake with wait-state tolerance and timeout. Sits between the memory port and the existing decoder, register file, ALU and writeback logic.

## Interface
- XLEN, 32: datapath and address width.
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- MAX_WAIT, 15: maximum cycles tolerated in any memory-wait state before a timeout trap; must be ≥ 1.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; sampled only in IDLE and WRITEBACK.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = read.
- mem_addr  out  XLEN  byte address.
- mem_wdata  out  XLEN  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response valid (read data or store ack).
- mem_rdata  in  XLEN  read data.
- dec_load, dec_store, dec_jump, dec_illegal  in  1 each  decoder class flags for the current ir.
- branch_taken  in  1  branch condition from the ALU.
- alu_result  in  XLEN  effective address or jump/branch target.
- store_data  in  XLEN  aligned store data from the DMI.
- pc  out  XLEN  current PC.
- ir  out  XLEN  latched instruction.
- load_data  out  XLEN  latched load response.
- rf_we  out  1  register-file write strobe, one cycle.
- retire  out  1  one-cycle pulse per completed instruction.
- busy  out  1  high in every state except IDLE and TRAP.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  0 = illegal, 1 = fetch timeout, 2 = data timeout, 3 = misaligned target.

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP.
- Reset values: state = IDLE, pc = RESET_PC, ir = 0, load_data = 0, trap_cause = 0. All strobes and mem_* outputs are 0.
- IDLE → FETCH_REQ when en = 1.
- FETCH_REQ: mem_req = 1, mem_we = 0, mem_addr = pc. On mem_gnt → FETCH_WAIT.
- FETCH_WAIT: on mem_rvalid, ir ← mem_rdata, then → DECODE.
- DECODE: one cycle for register-file read. → EXECUTE.
- EXECUTE: priority order:
  - dec_illegal → TRAP (cause 0).
  - dec_load or dec_store with alu_result[1:0] ≠ 0 → TRAP (cause 3).
  - dec_load or dec_store → MEM_REQ.
  - Otherwise → WRITEBACK.
- MEM_REQ: mem_req = 1, mem_we = dec_store, mem_addr = alu_result, mem_wdata = store_data. On mem_gnt → MEM_WAIT.
- MEM_WAIT: on mem_rvalid, load_data ← mem_rdata (loads only), then → WRITEBACK.
- WRITEBACK:
  - rf_we = !dec_store. retire = 1.
  - If dec_jump, or branch_taken: pc ← {alu_result[XLEN-1:1], 1'b0}. If bit 1 of that target is set → TRAP (cause 3), no retire, no rf_we.
  - Otherwise pc ← pc + 4, wrapping modulo 2^XLEN.
  - Next state: FETCH_REQ if en = 1, else IDLE.
- Timeout: a wait counter clears on entry to FETCH_REQ and MEM_REQ and counts every cycle in REQ/WAIT states. When the count reaches MAX_WAIT without the awaited gnt/rvalid → TRAP, cause 1 (fetch) or 2 (data).
- TRAP: mem_req = 0. pc and ir frozen. Only rst exits.
- Handshake rule: while mem_req is high, mem_addr, mem_we and mem_wdata stay stable until mem_gnt.
  - gnt and rvalid in the same cycle in a REQ state: accept both and go straight to the next non-wait state.
  - rvalid outside a WAIT state is ignored.
- en deasserted mid-instruction has no effect until WRITEBACK.
- rst asserted mid-transaction returns to IDLE immediately. Any outstanding memory response is dropped.

## Timing
- ALU instruction, zero-wait memory (gnt with req, rvalid next cycle): 5 cycles, FETCH_REQ → WRITEBACK.
- Load or store, zero-wait memory: 7 cycles.
- Each memory wait cycle adds 1.
- retire and rf_we are registered outputs valid during WRITEBACK. pc updates on the clock edge that leaves WRITEBACK.
- Timeout fires on the MAX_WAIT-th cycle spent in a REQ/WAIT pair.

## Structure
- mc_pkg holds the state enum, the trap cause constants TRAP_ILLEGAL, TRAP_FTO, TRAP_DTO and TRAP_MISALIGN, and the default parameter values.
- The sub-module mc_wait_timer contains the saturating counter, clear/enable inputs and expired output, with width $clog2(MAX_WAIT+1).
- The FSM, PC, ir and load_data registers live in multicycle_ctrl.

## Test plan
- Reset, en = 1, ADDI at 0x0, zero-wait memory → mem_req at cycle 1, retire at cycle 5, pc = 0x4, rf_we for one cycle.
- LW with 3-cycle rvalid delay, alu_result = 0x100 → mem_addr = 0x100 and mem_we = 0 held stable; load_data = mem_rdata; retire at cycle 10.
- JAL with alu_result = 0x41 → pc = 0x40. JALR with alu_result = 0x42 → trap = 1, cause 3, no retire.
- Fetch gnt withheld for MAX_WAIT = 15 cycles → trap, cause 1, busy = 0, mem_req = 0 thereafter.
- en dropped during EXECUTE → instruction completes, state = IDLE, no further mem_req until en = 1.
- rst pulsed low during MEM_WAIT → all outputs return to reset values asynchronously; after release with en = 1, fetch restarts at RESET_PC.
